// File: rtl/act_pkg.sv
// Shared definitions for the ACT_S2 round-robin scheduler: state codes and
// the layout of one requester's operand slice.
package act_pkg;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ISSUE    = 2'd1;
  localparam logic [1:0] S_COMPLETE = 2'd2;

  // Slice layout, LSB first: B0, A0, B1, A1, D00, D01, D10, D11
  localparam int unsigned OFF_B0  = 0;
  localparam int unsigned OFF_A0  = 1;
  localparam int unsigned OFF_B1  = 2;
  localparam int unsigned OFF_A1  = 3;
  localparam int unsigned OFF_D00 = 4;

  function automatic int unsigned act_op_w(input int unsigned xlen);
    return 4 * xlen + 4;
  endfunction

  // k = 0..3 selects D00, D01, D10, D11
  function automatic int unsigned act_off_d(input int unsigned xlen, input int unsigned k);
    return OFF_D00 + k * xlen;
  endfunction

endpackage

// File: rtl/act_s2_rr_scheduler_cell.sv
// Registered ACT_S2 logic cell: S0=A0&B0 and S1=A1|B1 select one of four data words.
module act_s2_cell #(
  parameter int unsigned XLEN = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] d00,
  input  logic [XLEN-1:0] d01,
  input  logic [XLEN-1:0] d10,
  input  logic [XLEN-1:0] d11,
  input  logic            a0,
  input  logic            b0,
  input  logic            a1,
  input  logic            b1,
  output logic [XLEN-1:0] q
);

  logic            w_s0;
  logic            w_s1;
  logic [XLEN-1:0] w_sel;

  assign w_s0 = a0 & b0;
  assign w_s1 = a1 | b1;

  // S0 is the outer select level, S1 the inner one
  always_comb begin
    w_sel = d00;
    case ({w_s0, w_s1})
      2'b00:   w_sel = d00;
      2'b01:   w_sel = d01;
      2'b10:   w_sel = d10;
      default: w_sel = d11;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) q <= '0;
    else       q <= w_sel;
  end

endmodule

// File: rtl/act_s2_rr_scheduler_picker.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping to 0.
module rr_picker #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [PW-1:0]   ptr,
  output logic            found,
  output logic [PW-1:0]   idx
);

  // Upper pass covers [ptr, NREQ-1]; lower pass then yields the wrapped winner below ptr
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && eligible[i] && (PW'(i) >= ptr)) begin
        found = 1'b1;
        idx   = PW'(i);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && eligible[i]) begin
        found = 1'b1;
        idx   = PW'(i);
      end
    end
  end

endmodule

// File: rtl/act_s2_rr_scheduler.sv
// Round-robin front-end sharing one registered ACT_S2 cell between NREQ requesters:
// captures operands at grant, drives the cell, pulses done with the cell result.
module act_s2_rr_scheduler
  import act_pkg::*;
#(
  parameter int unsigned XLEN = 2,
  parameter int unsigned NREQ = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ*(4*XLEN+4)-1:0]  req_ops,
  output logic [NREQ-1:0]             grant,
  output logic [NREQ-1:0]             done,
  output logic [XLEN-1:0]             result,
  output logic                        busy
);

  localparam int unsigned OP_W   = act_op_w(XLEN);
  localparam int unsigned PW     = $clog2(NREQ);
  localparam int unsigned D00_LO = act_off_d(XLEN, 0);
  localparam int unsigned D01_LO = act_off_d(XLEN, 1);
  localparam int unsigned D10_LO = act_off_d(XLEN, 2);
  localparam int unsigned D11_LO = act_off_d(XLEN, 3);

  logic [1:0]      r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_idx;
  logic [OP_W-1:0] r_op;
  logic [NREQ-1:0] r_done;

  logic [NREQ-1:0] w_elig;
  logic            w_found;
  logic [PW-1:0]   w_pick;
  logic [PW-1:0]   w_ptr_next;
  logic [NREQ-1:0] w_grant;
  logic [NREQ-1:0] w_idx_oh;
  logic [OP_W-1:0] w_slice;

  // The requester finishing in COMPLETE is masked so others get the slot first
  always_comb begin
    w_elig = '0;
    if (r_state == S_IDLE) begin
      w_elig = req;
    end else if (r_state == S_COMPLETE) begin
      w_elig        = req;
      w_elig[r_idx] = 1'b0;
    end
  end

  rr_picker #(.NREQ(NREQ)) u_picker (
    .eligible (w_elig),
    .ptr      (r_ptr),
    .found    (w_found),
    .idx      (w_pick)
  );

  assign w_ptr_next = (w_pick == PW'(NREQ - 1)) ? '0 : w_pick + 1'b1;

  always_comb begin
    w_grant = '0;
    if (w_found) w_grant[w_pick] = 1'b1;
  end

  always_comb begin
    w_idx_oh        = '0;
    w_idx_oh[r_idx] = 1'b1;
  end

  always_comb begin
    w_slice = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (PW'(i) == w_pick) w_slice = req_ops[i*OP_W +: OP_W];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_op    <= '0;
      r_done  <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE, S_COMPLETE: begin
          if (w_found) begin
            r_op    <= w_slice;
            r_idx   <= w_pick;
            r_ptr   <= w_ptr_next;
            r_state <= S_ISSUE;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          r_done  <= w_idx_oh;
          r_state <= S_COMPLETE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Cell always sees op_reg; its output is only consumed while done is high
  act_s2_cell #(.XLEN(XLEN)) u_cell (
    .clock (clock),
    .reset (reset),
    .d00   (r_op[D00_LO +: XLEN]),
    .d01   (r_op[D01_LO +: XLEN]),
    .d10   (r_op[D10_LO +: XLEN]),
    .d11   (r_op[D11_LO +: XLEN]),
    .a0    (r_op[OFF_A0]),
    .b0    (r_op[OFF_B0]),
    .a1    (r_op[OFF_A1]),
    .b1    (r_op[OFF_B1]),
    .q     (result)
  );

  assign grant = w_grant;
  assign done  = r_done;
  assign busy  = (r_state == S_ISSUE) || (r_state == S_COMPLETE);

endmodule

// File: tb/tb_act_s2_rr_scheduler.sv
// Scoreboard bench for act_s2_rr_scheduler (XLEN=2, NREQ=4): directed scenarios
// followed by random traffic, checked against a cycle-count based reference model.
module tb_act_s2_rr_scheduler;

  localparam int XLEN = 2;
  localparam int NREQ = 4;
  localparam int OPW  = 4 * XLEN + 4;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*OPW-1:0]    req_ops = '0;
  logic [NREQ-1:0]        grant;
  logic [NREQ-1:0]        done;
  logic [XLEN-1:0]        result;
  logic                   busy;

  act_s2_rr_scheduler #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .req_ops (req_ops),
    .grant   (grant),
    .done    (done),
    .result  (result),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int due;
    int idx;
    int res;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   armed    = 0;
  bit   stop_mon = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  // Result of one operand slice, straight from the cell's select rules
  function automatic int slice_result(input logic [NREQ*OPW-1:0] ops, input int w);
    logic [NREQ*OPW-1:0] s;
    int s0, s1, k;
    s  = ops >> (w * OPW);
    s0 = int'(s[1] & s[0]);
    s1 = int'(s[3] | s[2]);
    k  = s0 * 2 + s1;
    return int'((s >> (4 + XLEN * k)) & ((1 << XLEN) - 1));
  endfunction

  // Reference model: service slots tracked by the cycle of the last grant
  initial begin : model
    int ptr, lastg, lastw, d, w;
    bit rst_prev, fnd;
    logic [NREQ-1:0] elig, eg;
    ptr = 0; lastg = -100; lastw = 0; rst_prev = 0;
    forever begin
      @(negedge clock); #1;
      if (!armed) begin
        if (reset) begin
          armed = 1; rst_prev = 1; ptr = 0; lastg = -100;
        end
        continue;
      end
      d    = cyc - lastg;
      elig = (d >= 2) ? req : '0;
      if (d == 2) elig[lastw] = 1'b0;
      fnd = 0; w = 0;
      for (int k = 0; k < NREQ; k++) begin
        if (!fnd && elig[(ptr + k) % NREQ]) begin
          fnd = 1; w = (ptr + k) % NREQ;
        end
      end
      eg = '0;
      if (fnd) eg[w] = 1'b1;
      check("grant", int'(grant), int'(eg));
      check("busy", int'(busy), int'(d == 1 || d == 2));
      if (rst_prev) begin
        check("post_reset_result", int'(result), 0);
        check("post_reset_done", int'(done), 0);
      end
      if (reset) begin
        ptr = 0; lastg = -100;
        q.delete();
      end else if (fnd) begin
        lastg = cyc; lastw = w; ptr = (w + 1) % NREQ;
        q.push_back('{due: cyc + 2, idx: w, res: slice_result(req_ops, w)});
      end
      rst_prev = reset;
    end
  end

  // Monitor: pops an expectation whenever done is presented
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (!armed || stop_mon) continue;
      if (done != '0) begin
        if (q.size() == 0) begin
          check("unexpected_done", int'(done), 0);
        end else begin
          e = q.pop_front();
          check("done_cycle", cyc, e.due);
          check("done_onehot", int'(done), 1 << e.idx);
          check("result", int'(result), e.res);
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        check("missing_done", int'(done), 1 << e.idx);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_slice(input int i, input logic [OPW-1:0] v);
    req_ops[i*OPW +: OPW] = v;
  endtask

  initial begin
    step(3);
    reset = 0;
    step(2);

    // Single requester, S0=1 S1=0 -> D10 = 2
    set_slice(0, {2'd3, 2'd2, 2'd1, 2'd0, 4'b0011});
    req = 4'b0001;
    step(1);
    req = 4'b0000;
    step(4);

    // Two requesters alternate after reset
    reset = 1; step(1); reset = 0;
    for (int i = 0; i < NREQ; i++) set_slice(i, OPW'($urandom));
    req = 4'b0101;
    step(8);
    req = 4'b0000;
    step(4);

    // Full contention; slice 2 has A1=1, A0=B0=0 -> D01
    for (int i = 0; i < NREQ; i++) set_slice(i, OPW'($urandom));
    set_slice(2, {2'd0, 2'd0, 2'd3, 2'd0, 4'b1000});
    req = 4'b1111;
    step(10);
    req = 4'b0000;
    step(4);

    // Lone requester held: one grant every third cycle
    req = 4'b0100;
    step(9);
    req = 4'b0000;
    step(4);

    // Reset during ISSUE, request still held afterwards
    req = 4'b0001;
    step(1);
    reset = 1;
    step(1);
    reset = 0;
    step(4);
    req = 4'b0000;
    step(4);

    // Operands and request change after grant must not affect the result
    set_slice(1, {2'd1, 2'd2, 2'd3, 2'd1, 4'b0101});
    req = 4'b0010;
    step(1);
    set_slice(1, OPW'($urandom));
    req = 4'b0000;
    step(5);

    // Random traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      req     = NREQ'($urandom);
      req_ops = {$urandom, $urandom};
      reset   = ($urandom_range(0, 49) == 0);
      step(1);
    end
    reset = 0;
    req   = '0;
    step(6);

    stop_mon = 1;
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
